// File: rtl/kulisch_to_fp16.sv
// ============================================================================
// kulisch_to_fp16 : 91-bit Kulisch accumulator word -> FP16 (RNE), multi-cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module kulisch_to_fp16 #(
  parameter int AWIDTH = 91,
  parameter int FBITS  = 48,
  parameter int CHUNK  = 8,
  parameter int NCHUNK = (AWIDTH + CHUNK - 1) / CHUNK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AWIDTH-1:0] i_kulisch_acc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [15:0]       o_fp_data,
  output logic              o_inexact,
  output logic              o_overflow
);

  localparam int PW = NCHUNK * CHUNK;
  localparam int LW = $clog2(PW);
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int HW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_SCAN  = 3'd2,
    S_ROUND = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] mag_q, mag_d;
  logic              sign_q, sign_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              found_q, found_d;
  logic [LW-1:0]     lead_q, lead_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [15:0]       fp_q, fp_d;
  logic              inexact_q, inexact_d;
  logic              overflow_q, overflow_d;

  logic [PW-1:0]     mag_ext;
  logic [CHUNK-1:0]  chunk_bits;
  logic              hit;
  logic [HW-1:0]     hit_idx;

  assign mag_ext    = PW'(mag_q);
  assign chunk_bits = mag_ext[cnt_q*CHUNK +: CHUNK];

  // Highest set bit of the current chunk (later iterations win).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk_bits[i]) begin
        hit     = 1'b1;
        hit_idx = HW'(i);
      end
    end
  end

  logic [15:0]   rnd_fp;
  logic          rnd_inexact, rnd_overflow;
  logic [9:0]    keep;
  logic          guard, sticky;
  logic [4:0]    exp_f;
  logic [14:0]   sum;
  logic [LW-1:0] sh;

  always_comb begin
    rnd_fp       = '0;
    rnd_inexact  = 1'b0;
    rnd_overflow = 1'b0;
    keep         = '0;
    guard        = 1'b0;
    sticky       = 1'b0;
    exp_f        = '0;
    sum          = '0;
    sh           = '0;
    if (!found_q) begin
      rnd_fp = 16'h0000;
    end else if (int'(lead_q) >= FBITS + 16) begin
      rnd_fp       = {sign_q, 5'h1F, 10'h000};
      rnd_inexact  = 1'b1;
      rnd_overflow = 1'b1;
    end else begin
      if (int'(lead_q) >= FBITS - 14) begin
        // sh is the bit position of the mantissa LSB; hidden bit is dropped by the cast.
        sh     = lead_q - LW'(10);
        keep   = 10'(mag_ext >> sh);
        guard  = mag_ext[sh - LW'(1)];
        sticky = |(mag_ext & ((PW'(1) << (sh - LW'(1))) - PW'(1)));
        exp_f  = 5'(int'(lead_q) - FBITS + 15);
      end else begin
        keep   = mag_ext[FBITS-15 -: 10];
        guard  = mag_ext[FBITS-25];
        sticky = |mag_ext[FBITS-26:0];
        exp_f  = 5'd0;
      end
      // Mantissa carry ripples straight into the exponent field.
      sum          = {exp_f, keep} + 15'(guard && (sticky || keep[0]));
      rnd_fp       = {sign_q, sum};
      rnd_inexact  = guard | sticky;
      rnd_overflow = (sum[14:10] == 5'h1F);
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    sign_d     = sign_q;
    cnt_d      = cnt_q;
    found_d    = found_q;
    lead_d     = lead_q;
    fp_d       = fp_q;
    inexact_d  = inexact_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          mag_d   = i_kulisch_acc;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        sign_d  = mag_q[AWIDTH-1];
        mag_d   = mag_q[AWIDTH-1] ? (~mag_q + AWIDTH'(1)) : mag_q;
        cnt_d   = CW'(NCHUNK - 1);
        found_d = 1'b0;
        lead_d  = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!found_q && hit) begin
          found_d = 1'b1;
          lead_d  = LW'(int'(cnt_q) * CHUNK + int'(hit_idx));
        end
        if (cnt_q == '0) state_d = S_ROUND;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_ROUND: begin
        fp_d       = rnd_fp;
        inexact_d  = rnd_inexact;
        overflow_d = rnd_overflow;
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (valid_q && i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_q == S_OUT) && !(valid_q && i_ready);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      lead_q     <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      fp_q       <= '0;
      inexact_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      sign_q     <= sign_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      lead_q     <= lead_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      fp_q       <= fp_d;
      inexact_q  <= inexact_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_fp_data  = fp_q;
  assign o_inexact  = inexact_q;
  assign o_overflow = overflow_q;

endmodule

`default_nettype wire
